// File: rtl/switch_debounce_pulse.sv
// switch_debounce_pulse: per-channel 2-flop sync, debounce and edge-selected one-cycle pulse.
// Define SWITCH_DEBOUNCE_PULSE_AUTOREPEAT_EN to add held-key repeat pulses.
module switch_debounce_pulse #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_pulse,
  output logic             sw_any
);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic RISE_EN = (EDGE_MODE != 1);
  localparam logic FALL_EN = (EDGE_MODE == 1) || (EDGE_MODE == 2);
  if (DEBOUNCE_CYCLES < 1 || CNT_W < $clog2(DEBOUNCE_CYCLES + 1) ||
      CNT_W < $clog2(REPEAT_DELAY + 1) || CNT_W < $clog2(REPEAT_PERIOD + 1)) begin : g_bad_cfg
    $error("switch_debounce_pulse: CNT_W too narrow or DEBOUNCE_CYCLES < 1");
  end
  logic [WIDTH-1:0] s1_q, s2_q, level_q, level_d, pulse_q, pulse_d;
  logic             any_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
`ifdef SWITCH_DEBOUNCE_PULSE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_MAX = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rep_q [WIDTH];
  logic [CNT_W-1:0] rep_d [WIDTH];
  logic [WIDTH-1:0] first_q, first_d;
`endif
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          level_d[i] = s2_q[i];
          pulse_d[i] = s2_q[i] ? RISE_EN : FALL_EN;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
`ifdef SWITCH_DEBOUNCE_PULSE_AUTOREPEAT_EN
      rep_d[i]   = '0;
      first_d[i] = 1'b1;
      if (level_q[i] && level_d[i]) begin
        first_d[i] = first_q[i];
        if (rep_q[i] == (first_q[i] ? RD_MAX : RP_MAX)) begin
          pulse_d[i] = 1'b1;
          first_d[i] = 1'b0;
        end else begin
          rep_d[i] = rep_q[i] + 1'b1;
        end
      end
`endif
    end
  end
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
`ifdef SWITCH_DEBOUNCE_PULSE_AUTOREPEAT_EN
      for (int i = 0; i < WIDTH; i++) rep_q[i] <= '0;
      first_q <= '1;
`endif
    end else begin
      s1_q    <= sw_in;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      any_q   <= |pulse_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
`ifdef SWITCH_DEBOUNCE_PULSE_AUTOREPEAT_EN
      for (int i = 0; i < WIDTH; i++) rep_q[i] <= rep_d[i];
      first_q <= first_d;
`endif
    end
  end
  assign sw_level = level_q;
  assign sw_pulse = pulse_q;
  assign sw_any   = any_q;
endmodule
